alsu_issue_stage: RTL and testbench
===================================

// Module: alsu_issue_stage
// PURPOSE
//   Upstream issue stage for the bypass/equality/SLT unit. Buffers incoming {A,B,Sel} commands in a small FIFO.
//   Drives the unit's A/B/Sel inputs from registers, captures its 4-bit Out one cycle later, and presents the
//   result on a valid/ready port. Decouples the command source from the result consumer. One result per 2 cycles.
// PARAMETERS
//   WIDTH  4  operand / result width
//   SEL_W  2  select width (00 bypass A, 01 bypass B, 10 A==B, 11 A<B unsigned)
//   DEPTH  2  command FIFO depth, power of 2, >=2
// PORTS
//   clk        in   1                  clock, rising edge
//   rst        in   1                  reset, asynchronous, active-high
//   in_valid   in   1                  command valid
//   in_ready   out  1                  FIFO can accept (count < DEPTH)
//   in_A       in   WIDTH              command operand A
//   in_B       in   WIDTH              command operand B
//   in_Sel     in   SEL_W              command select
//   A          out  WIDTH              registered operand A to the unit
//   B          out  WIDTH              registered operand B to the unit
//   Sel        out  SEL_W              registered select to the unit
//   alu_Out    in   WIDTH              combinational Out returned by the unit
//   res_valid  out  1                  result valid
//   res_ready  in   1                  consumer accepts result
//   res_Out    out  WIDTH              captured result
//   res_Sel    out  SEL_W              select tag of captured result
//   count      out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, FIFO pointers and count=0, A=B=0, Sel=0, res_valid=0, res_Out=0,
//     res_Sel=0. in_ready=1 once rst deasserts. Contents in flight are discarded, with no partial result.
//   Push: in_valid&&in_ready at an edge writes tail, tail=(tail+1)%DEPTH.
//     in_ready depends only on count, with no same-cycle pass-through.
//     At full, in_ready=0. The source holds in_valid and data. Nothing is overwritten or dropped.
//   Pop: moves head entry into A/B/Sel registers, head=(head+1)%DEPTH.
//     count updates by +push-pop. Simultaneous push and pop leaves count unchanged.
//   FSM:
//     IDLE: count>0 -> pop, go EXEC. Otherwise stay. A/B/Sel keep their last values.
//     EXEC: one cycle for the unit to settle. At the edge, res_Out<=alu_Out, res_Sel<=Sel, res_valid<=1, go HOLD.
//     HOLD: res_valid=1. res_Out/res_Sel/A/B/Sel stay stable until res_ready.
//       On res_valid&&res_ready with count>0 -> pop next, go EXEC. Drop res_valid that edge.
//       On res_valid&&res_ready with count==0 -> res_valid<=0, go IDLE.
//   Latency: command pushed at edge k (FIFO empty, IDLE) -> A/B/Sel updated at k+1 -> res_valid=1 after k+2.
//   Ordering: results leave in strict command order. The entry popped that edge counts for count and in_ready.
//   A push that lands in the same cycle as a HOLD->EXEC pop is accepted if count<DEPTH before the edge.
//   Arithmetic: unit output is used as-is. The stage never modifies operands or results.
// TESTING
//   1 Reset mid-HOLD (res_ready=0, 2 queued): raise rst between edges.
//     -> Immediately res_valid=0, count=0, A=B=0, Sel=00, in_ready=1 after release.
//   2 Single cmd A=1000 B=1000 Sel=10, res_ready=1.
//     -> res_valid high 2 edges after accept, res_Out=0001, res_Sel=10, then IDLE.
//   3 res_ready=0, offer 4 cmds: (0101,0000,00), (0000,1010,01), (0000,1111,11), (1000,0100,11).
//     -> First 3 accepted, 4th stalls with in_ready=0, count=2.
//     -> Then res_ready=1 gives 0101, 1010, 0001, 0000 in order.
//   4 Stream 7 cmds with res_ready toggling every cycle.
//     -> Pointers wrap, no loss or duplicate, each result matches the unit golden model. count never exceeds DEPTH.
//   5 SLT/equality boundaries: (0111,0111,11)->0000, (1111,1111,10)->0001, (0000,0001,11)->0001.
//     -> res_Sel carries 11, 10, 11.
//   6 in_valid held while full, and res_ready pulsed in the same cycle.
//     -> Push is accepted only on the edge after count drops. Data is unchanged.

Source files
------------

// File: rtl/alsu_issue_stage.sv
// Issue stage for the bypass/equality/SLT unit: queues {A,B,Sel} commands, drives the unit
// from registers, captures its Out one cycle later and offers it on a valid/ready result port.
module alsu_issue_stage #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_A,
  input  logic [WIDTH-1:0]         in_B,
  input  logic [SEL_W-1:0]         in_Sel,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic [SEL_W-1:0]         Sel,
  input  logic [WIDTH-1:0]         alu_Out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_Out,
  output logic [SEL_W-1:0]         res_Sel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  logic             res_fire;

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // the producer holds valid and data stable until then, and ready never looks at valid.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign res_fire = res_valid && res_ready;
  assign pop      = (count != '0) && ((state == IDLE) || ((state == HOLD) && res_fire));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[tail]   <= in_A;
      mem_b[tail]   <= in_B;
      mem_sel[tail] <= in_Sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The unit is combinational, so EXEC is the settle cycle between loading A/B/Sel and capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      A         <= '0;
      B         <= '0;
      Sel       <= '0;
      res_valid <= 1'b0;
      res_Out   <= '0;
      res_Sel   <= '0;
    end else begin
      if (pop) begin
        A   <= mem_a[head];
        B   <= mem_b[head];
        Sel <= mem_sel[head];
      end
      case (state)
        IDLE: begin
          if (pop) state <= EXEC;
        end
        EXEC: begin
          res_Out   <= alu_Out;
          res_Sel   <= Sel;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_issue_stage.sv
// Self-checking bench for alsu_issue_stage: emulates the unit, scoreboards results in order,
// and checks reset, latency, back-pressure, pointer wrap and compare boundaries.
module tb_alsu_issue_stage;

  localparam int W  = 4;
  localparam int SW = 2;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_A;
  logic [W-1:0]  in_B;
  logic [SW-1:0] in_Sel;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [SW-1:0] Sel;
  logic [W-1:0]  alu_Out;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_Out;
  logic [SW-1:0] res_Sel;
  logic [$clog2(D):0] count;

  logic [W-1:0]        in_exp;
  logic [SW+W-1:0]     exp_q[$];
  int                  errors = 0;
  int                  checks = 0;
  int                  rcv    = 0;
  logic                stream_done;

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [SW-1:0] s);
    case (s)
      2'b00:   golden = a;
      2'b01:   golden = b;
      2'b10:   golden = {3'b000, a == b};
      default: golden = {3'b000, a < b};
    endcase
  endfunction

  assign alu_Out = golden(A, B, Sel);

  alsu_issue_stage #(.WIDTH(W), .SEL_W(SW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_Sel(in_Sel), .A(A), .B(B), .Sel(Sel),
    .alu_Out(alu_Out), .res_valid(res_valid), .res_ready(res_ready),
    .res_Out(res_Out), .res_Sel(res_Sel), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs change only at posedge+1, so what is seen at negedge is what the edge takes.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back({in_Sel, in_exp});
      checks++;
      if (count > 3'(D)) begin
        errors++;
        $display("FAIL count_bound: got %0d limit %0d", count, D);
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sel=%b out=%b with nothing expected", res_Sel, res_Out);
        end else begin
          logic [SW+W-1:0] e;
          e = exp_q.pop_front();
          rcv++;
          if ({res_Sel, res_Out} !== e)
          begin
            errors++;
            $display("FAIL result: got sel=%b out=%b expected sel=%b out=%b",
                     res_Sel, res_Out, e[SW+W-1:W], e[W-1:0]);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] s,
                      input logic [W-1:0] e);
    logic got;
    got = 1'b0;
    in_A = a; in_B = b; in_Sel = s; in_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_accept: got no accept for a=%b b=%b sel=%b", a, b, s);
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid && count == 0) done = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d results still pending, count=%0d", exp_q.size(), count);
    end
  endtask

  task automatic test_reset();
    logic got;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    in_A = '0; in_B = '0; in_Sel = '0; in_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, count, A, B, Sel, res_Out, res_Sel} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rv=%b cnt=%0d A=%b B=%b Sel=%b out=%b rsel=%b expected all zero",
               res_valid, count, A, B, Sel, res_Out, res_Sel);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    // Fill to HOLD with two queued, then reset between edges.
    send(4'b0011, 4'b0100, 2'b00, 4'b0011);
    send(4'b0110, 4'b0001, 2'b01, 4'b0001);
    send(4'b1001, 4'b1001, 2'b10, 4'b0001);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (res_valid && count == 2) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_prefill: got rv=%b cnt=%0d expected rv=1 cnt=2", res_valid, count);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({res_valid, count, A, B, Sel} !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: got rv=%b cnt=%0d A=%b B=%b Sel=%b expected all zero",
               res_valid, count, A, B, Sel);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || count !== 0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b rv=%b cnt=%0d expected 1 0 0", in_ready, res_valid, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    send(4'b1000, 4'b1000, 2'b10, 4'b0001);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_k: got rv=%b expected 0", res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || A !== 4'b1000 || B !== 4'b1000 || Sel !== 2'b10) begin
      errors++;
      $display("FAIL single_k1: got rv=%b A=%b B=%b Sel=%b expected 0 1000 1000 10", res_valid, A, B, Sel);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_Out !== 4'b0001 || res_Sel !== 2'b10) begin
      errors++;
      $display("FAIL single_k2: got rv=%b out=%b sel=%b expected 1 0001 10", res_valid, res_Out, res_Sel);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || count !== 0) begin
      errors++;
      $display("FAIL single_idle: got rv=%b cnt=%0d expected 0 0", res_valid, count);
    end
  endtask

  task automatic test_stall();
    int  rcv0;
    logic got;
    rcv0 = rcv;
    res_ready = 1'b0;
    send(4'b0101, 4'b0000, 2'b00, 4'b0101);
    send(4'b0000, 4'b1010, 2'b01, 4'b1010);
    send(4'b0000, 4'b1111, 2'b11, 4'b0001);
    in_A = 4'b1000; in_B = 4'b0100; in_Sel = 2'b11; in_exp = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || count !== 2) begin
        errors++;
        $display("FAIL stall_full: got in_ready=%b cnt=%0d expected 0 2", in_ready, count);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL stall_accept: got no accept of 4th command");
    end
    drain();
    checks++;
    if (rcv - rcv0 != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d results expected 4", rcv - rcv0);
    end
  endtask

  task automatic test_stream();
    int rcv0;
    rcv0 = rcv;
    res_ready = 1'b0;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          logic [W-1:0]  a;
          logic [W-1:0]  b;
          logic [SW-1:0] s;
          a = W'($urandom_range(0, 15));
          b = (i == 2) ? a : W'($urandom_range(0, 15));
          s = SW'(i % 4);
          send(a, b, s, golden(a, b, s));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          res_ready = ~res_ready;
        end
      end
    join
    drain();
    checks++;
    if (rcv - rcv0 != 7) begin
      errors++;
      $display("FAIL stream_count: got %0d results expected 7", rcv - rcv0);
    end
  endtask

  task automatic test_boundary();
    int rcv0;
    rcv0 = rcv;
    res_ready = 1'b1;
    send(4'b0111, 4'b0111, 2'b11, 4'b0000);
    send(4'b1111, 4'b1111, 2'b10, 4'b0001);
    send(4'b0000, 4'b0001, 2'b11, 4'b0001);
    drain();
    checks++;
    if (rcv - rcv0 != 3) begin
      errors++;
      $display("FAIL boundary_count: got %0d results expected 3", rcv - rcv0);
    end
  endtask

  task automatic test_full_pulse();
    res_ready = 1'b0;
    send(4'b0010, 4'b0011, 2'b11, 4'b0001);
    send(4'b1100, 4'b0011, 2'b00, 4'b1100);
    send(4'b0100, 4'b0101, 2'b10, 4'b0000);
    in_A = 4'b1110; in_B = 4'b0111; in_Sel = 2'b01; in_exp = 4'b0111; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || count !== 2) begin
      errors++;
      $display("FAIL pulse_before: got in_ready=%b cnt=%0d expected 0 2", in_ready, count);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || count !== 1) begin
      errors++;
      $display("FAIL pulse_after: got in_ready=%b cnt=%0d expected 1 1", in_ready, count);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (count !== 2) begin
      errors++;
      $display("FAIL pulse_push: got cnt=%0d expected 2", count);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_boundary();
    test_full_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
